// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions for the memory stage: control-bit positions,
// FSM encoding and the pipeline register layouts.
package memory_stage_pkg;

   // Bit positions inside the 4-bit execute/memory control bundle
   // {regwrite, memtoreg, memread, memwrite}.
   localparam logic [1:0] REGWRITE = 2'd3;
   localparam logic [1:0] MEMTOREG = 2'd2;
   localparam logic [1:0] MEMREAD  = 2'd1;
   localparam logic [1:0] MEMWRITE = 2'd0;

   // Bit positions inside the 2-bit writeback control bundle {regwrite, memtoreg}.
   localparam logic [0:0] W_REGWRITE = 1'd1;
   localparam logic [0:0] W_MEMTOREG = 1'd0;

   // Bus access FSM encoding.
   typedef enum logic {
      StIdle   = 1'b0,
      StAccess = 1'b1
   } mem_state_e;

   // M pipeline register contents.
   typedef struct packed {
      logic [3:0]  ctrls;
      logic [31:0] aluout;
      logic [31:0] writedata;
      logic [4:0]  writereg;
      logic        valid;
   } m_reg_t;

   // W pipeline register contents.
   typedef struct packed {
      logic [1:0]  ctrls;
      logic [31:0] aluout;
      logic [31:0] readdata;
      logic [4:0]  writereg;
      logic        valid;
      logic        misalign;
   } w_reg_t;

   // True for any instruction that touches data memory.
   function automatic logic is_mem_op(input logic [3:0] ctrls);
      return ctrls[MEMREAD] | ctrls[MEMWRITE];
   endfunction

   // True when an instruction will actually issue a bus transaction:
   // valid, a memory op, and word aligned.
   function automatic logic needs_access(input logic        valid,
                                         input logic [3:0]  ctrls,
                                         input logic [31:0] addr);
      return valid & is_mem_op(ctrls) & (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/writeback_register.sv
// W pipeline register: clears on reset, loads when enabled, holds otherwise.
module writeback_register
   import memory_stage_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   en,
   input  w_reg_t d,
   output w_reg_t q
);

   // Reset wins over the enable so a stalled stage still clears.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: holds the M register, runs a single-outstanding
// data-memory access FSM, stalls upstream while waiting for ack, and feeds
// the W register with ALU result, load data and a misalignment flag.
module memory_stage
   import memory_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   // Execute side
   input  logic [3:0]  ctrls_e,
   input  logic [31:0] aluout_e,
   input  logic [31:0] writedata_e,
   input  logic [4:0]  writereg_e,
   input  logic        valid_e,
   // Data memory
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   // Hazard / forwarding
   output logic        stall_m,
   output logic        regwrite_m,
   output logic [31:0] aluout_m,
   output logic [4:0]  writereg_m,
   // Writeback side
   output logic [1:0]  ctrls_w,
   output logic [31:0] aluout_w,
   output logic [31:0] readdata_w,
   output logic [4:0]  writereg_w,
   output logic        valid_w,
   output logic        misalign_w
);

   m_reg_t     m_q, m_d;
   w_reg_t     w_q, w_d;
   mem_state_e state_q, state_d;

   logic in_access;
   logic qual_e;
   logic misalign_m;

   assign in_access = (state_q == StAccess);
   assign qual_e    = needs_access(valid_e, ctrls_e, aluout_e);
   assign stall_m   = in_access & ~dmem_ack;

   // Next M contents straight from the execute stage.
   always_comb begin
      m_d           = '0;
      m_d.ctrls     = ctrls_e;
      m_d.aluout    = aluout_e;
      m_d.writedata = writedata_e;
      m_d.writereg  = writereg_e;
      m_d.valid     = valid_e;
   end

   // M register: frozen while the bus access is waiting for ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_q <= '0;
      end else if (!stall_m) begin
         m_q <= m_d;
      end
   end

   // FSM state register; reset abandons any in-flight access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: enter ACCESS when M captures a qualifying op; on ack, stay
   // in ACCESS only if the op loaded on that same edge qualifies as well.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (qual_e) begin
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (dmem_ack) begin
               state_d = qual_e ? StAccess : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus outputs come from M, so they stay stable until ack releases the stall.
   always_comb begin
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      if (in_access) begin
         dmem_req   = 1'b1;
         dmem_we    = m_q.ctrls[MEMWRITE];
         dmem_addr  = m_q.aluout;
         dmem_wdata = m_q.writedata;
      end
   end

   // Forwarding view of M; bubbles look like no-ops.
   always_comb begin
      regwrite_m = m_q.valid & m_q.ctrls[REGWRITE];
      aluout_m   = m_q.valid ? m_q.aluout : '0;
      writereg_m = m_q.valid ? m_q.writereg : '0;
   end

   assign misalign_m = m_q.valid & is_mem_op(m_q.ctrls) & (m_q.aluout[1:0] != 2'b00);

   // Next W contents; bubbles are all zero, misaligned ops lose regwrite, and
   // read data is only taken on the ack edge of a load.
   always_comb begin
      w_d = '0;
      if (m_q.valid) begin
         w_d.ctrls[W_REGWRITE] = m_q.ctrls[REGWRITE] & ~misalign_m;
         w_d.ctrls[W_MEMTOREG] = m_q.ctrls[MEMTOREG];
         w_d.aluout            = m_q.aluout;
         w_d.writereg          = m_q.writereg;
         w_d.valid             = 1'b1;
         w_d.misalign          = misalign_m;
         if (in_access && dmem_ack && m_q.ctrls[MEMREAD]) begin
            w_d.readdata = dmem_rdata;
         end
      end
   end

   writeback_register u_writeback_register (
      .clk   (clk),
      .reset (reset),
      .en    (~stall_m),
      .d     (w_d),
      .q     (w_q)
   );

   assign ctrls_w    = w_q.ctrls;
   assign aluout_w   = w_q.aluout;
   assign readdata_w = w_q.readdata;
   assign writereg_w = w_q.writereg;
   assign valid_w    = w_q.valid;
   assign misalign_w = w_q.misalign;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 SHALL provide these execute-side inputs: ctrls_e input 4 [regwrite,memtoreg,memread,memwrite]; aluout_e input 32; writedata_e input 32; writereg_e input 5; valid_e input 1.
REQ-003 SHALL provide these data-memory ports: dmem_req output 1; dmem_we output 1; dmem_addr output 32; dmem_wdata output 32; dmem_rdata input 32; dmem_ack input 1.
REQ-004 SHALL provide these hazard/forwarding ports: stall_m output 1, freezes upstream stages; regwrite_m output 1; aluout_m output 32; writereg_m output 5.
REQ-005 SHALL provide these writeback-side outputs: ctrls_w output 2 [regwrite,memtoreg]; aluout_w output 32; readdata_w output 32; writereg_w output 5; valid_w output 1; misalign_w output 1.

Function
REQ-006 SHALL hold an M register (ctrls, aluout, writedata, writereg, valid) that loads the execute inputs on each rising edge where stall_m=0.
REQ-007 SHALL hold a W register that loads on each rising edge where stall_m=0: M contents, readdata, misalign flag.
REQ-008 SHALL implement FSM states IDLE and ACCESS.
- IDLE->ACCESS: edge where M loads a valid memread or memwrite with aligned address (aluout_e[1:0]=0).
- ACCESS->IDLE: edge with dmem_ack=1, unless the newly loaded M also qualifies; in that case stay in ACCESS.
REQ-009 SHALL drive the memory bus only in ACCESS.
- dmem_req=1; dmem_we=memwrite_m; dmem_addr=aluout_m; dmem_wdata=writedata_m.
- Outside ACCESS, all four are 0.
REQ-010 SHALL drive stall_m = (state==ACCESS) & ~dmem_ack, combinationally.
REQ-011 SHALL capture dmem_rdata into readdata_w on the ack edge for loads; otherwise readdata_w loads 0.
REQ-012 SHALL keep dmem_addr/dmem_wdata/dmem_we stable while dmem_req=1 and dmem_ack=0.
REQ-013 SHALL ignore dmem_ack while in IDLE.
REQ-014 SHALL give a non-memory instruction one-cycle M->W latency.
REQ-015 SHALL give a memory instruction M->W latency of 1+k cycles, where k = wait cycles before ack; zero-wait ack gives one instruction per cycle.
REQ-016 SHALL handle a misaligned memory op (memread|memwrite, aluout[1:0]!=0) as follows: no bus request, stay IDLE, W gets misalign_w=1 and ctrls_w regwrite=0.
REQ-017 SHALL treat valid_m=0 as a bubble: no request, W receives valid_w=0 and ctrls_w=0.
REQ-018 SHALL drive regwrite_m/aluout_m/writereg_m directly from the M register, gated by valid_m.
REQ-019 SHALL hold both M and W while stall_m=1, with no duplicate W writes.

Reset
REQ-020 SHALL, on a clk edge with reset=1, clear all M and W fields to 0, state to IDLE, and all outputs to 0 on the next cycle.
REQ-021 SHALL, on reset during ACCESS, abandon the transaction: dmem_req drops the following cycle, and a late ack is ignored per REQ-013.
REQ-022 SHALL give reset priority over dmem_ack and stall.

Structure
REQ-023 SHALL place the following in the shared pipeline package: control-bit index constants (REGWRITE, MEMTOREG, MEMREAD, MEMWRITE) and the FSM state encoding.
REQ-024 SHALL implement the W register as sub-module writeback_register with enable, instantiated once; the M register and FSM stay inline.

Verification
REQ-025 SHALL verify ALU op, aluout_e=0x10, writereg_e=5, regwrite=1 -> aluout_w=0x10, writereg_w=5 two edges later; stall_m never 1.
REQ-026 SHALL verify load at 0x100 with ack after 3 wait cycles and rdata=0xDEADBEEF -> stall_m=1 for 3 cycles, readdata_w=0xDEADBEEF, memtoreg_w=1.
REQ-027 SHALL verify back-to-back stores to 0x0 and 0x4 with zero-wait ack -> dmem_we=1 on two consecutive cycles, stall_m=0, addresses in order.
REQ-028 SHALL verify load at 0x102 -> dmem_req stays 0, misalign_w=1, regwrite_w=0.
REQ-029 SHALL verify reset asserted mid-ACCESS, then ack pulsed -> dmem_req=0 after reset, W outputs 0, no readdata capture.
REQ-030 SHALL verify valid_e=0 bubble between two loads -> valid_w=0 slot, no extra dmem_req pulse.
